ft_sync_rx: RTL and testbench
=============================

Name: ft_sync_rx

Overview:
- Host-to-FPGA receive controller for the FT2232H 245 synchronous FIFO interface, running on comm_clk (60 MHz CLKOUT).
- Complements the existing transmit path (txe/wr).
- Drives the active-low oe and rd strobes and captures bytes from the FT2232H data bus into a small internal buffer.
- Presents the bytes to FPGA logic as a valid/ready stream; the top level owns the tristate bus and the half-duplex arbitration.

Parameters:
- FIFO_DEPTH, 8, receive buffer depth in bytes; power of two, >= 4.
- AFULL_MARGIN, 2, free entries reserved for the in-flight byte after rd deasserts; >= 1, < FIFO_DEPTH.

Ports:
- comm_clk  in  1  FT2232H CLKOUT; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rxf  in  1  FT2232H RXF#, active-low; 0 = host data available.
- data_in  in  8  FT2232H ADBUS input (bus driven by the FT2232H while oe = 0).
- oe  out  1  FT2232H OE#, active-low.
- rd  out  1  FT2232H RD#, active-low.
- rx_en  in  1  arbiter grant; 1 = receiver may own the bus.
- rx_active  out  1  1 while oe = 0; FPGA bus drivers must be off.
- m_data  out  8  head byte of the buffer.
- m_valid  out  1  buffer non-empty.
- m_ready  in  1  consumer accepts m_data on an edge where m_valid = 1.
- overflow  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset values: oe = 1, rd = 1, rx_active = 0, m_valid = 0, m_data = 0, overflow = 0, count = 0, state = IDLE.
- Reset mid-burst: oe and rd return to 1 on the reset edge, and buffer contents are discarded.
- room = (count < FIFO_DEPTH - AFULL_MARGIN), evaluated on the pre-edge count.
- oe, rd and rx_active are registered outputs, with no combinational path from inputs.

State machine (3 states):
- IDLE
  - If rx_en = 1, rxf = 0 and room, go to OE_WAIT and set oe <= 0.
  - Otherwise stay; oe and rd stay 1.
- OE_WAIT (exactly 1 cycle, bus turnaround)
  - If rx_en = 1, rxf = 0 and room, go to READ and set rd <= 0.
  - Otherwise go to IDLE and set oe <= 1.
- READ (oe = 0, rd = 0)
  - Capture: on every edge with rxf = 0, data_in is pushed into the buffer.
  - Exit: on the first edge where rxf = 1, rx_en = 0 or !room, set rd <= 1 and oe <= 1 and go to IDLE.
  - A capture on that same exit edge still occurs if rxf = 0.
- After IDLE is entered, at least one IDLE cycle passes before OE_WAIT (turnaround).
- No byte is ever captured outside READ.

Buffer:
- Synchronous FIFO with read-first head: m_data and m_valid are registered, and the pop is combinational on m_ready.
- Push latency: a byte captured at edge k is visible on m_data / m_valid after edge k+1 at the latest.
- Simultaneous push and pop leaves count unchanged and keeps ordering.
- Pointers wrap modulo FIFO_DEPTH.
- Push when count = FIFO_DEPTH with no pop: the byte is dropped and overflow <= 1. This must be unreachable with a legal AFULL_MARGIN.
- m_data holds its value while m_valid = 1 and m_ready = 0.

Throughput:
- Burst reads sustain 1 byte per comm_clk with m_ready = 1.
- Per-burst overhead is 1 cycle (OE_WAIT) plus 1 idle cycle.

Test Plan:
1. Single byte: rxf low for exactly 1 cycle in READ with data_in = 0xA5, m_ready = 1.
   -> oe low 1 cycle before rd; one byte 0xA5 on m_data; rd/oe high the edge after rxf = 1 is sampled.
2. Long burst: 20 bytes 0x00..0x13, rxf held low, m_ready = 1.
   -> rd low for 20 consecutive cycles; m_data emits 0x00..0x13 in order; overflow = 0.
3. Backpressure (DEPTH 8, MARGIN 2): 20 bytes available, m_ready = 0.
   -> exactly 7 bytes captured, then rd = 1; count = 7, overflow = 0.
   -> Then m_ready = 1: 7 bytes drain, the read restarts via OE_WAIT, and all 20 bytes arrive in order.
4. rxf deasserts mid-burst after byte 5, then reasserts 3 cycles later.
   -> 5 bytes captured, IDLE for at least 1 cycle, OE_WAIT, and the burst resumes with no duplicated or lost byte.
5. rx_en drops during READ.
   -> rd and oe high on the next edge, rx_active = 0 on that cycle.
   -> No new OE_WAIT is entered while rx_en = 0; buffered bytes still drain.
6. rst asserted mid-burst with 3 bytes buffered.
   -> Next edge: oe = 1, rd = 1, m_valid = 0, overflow = 0.
   -> After release with rxf low, normal OE_WAIT then READ sequence.

Source files
------------

// File: rtl/ft_sync_rx.sv
// ft_sync_rx: receive controller for the FT2232H 245 synchronous FIFO mode.
//
// Drives the active-low OE#/RD# strobes on comm_clk (60 MHz CLKOUT) and
// captures host bytes into a small FIFO. The FIFO is presented to FPGA
// logic as a valid/ready stream. Bus tristate control and half-duplex
// arbitration live in the parent; rx_active tells it to release the bus.
//
// Ports:
//   comm_clk   in   FT2232H CLKOUT, rising edge only
//   rst        in   synchronous active-high reset
//   rxf        in   RXF#, 0 = host has data
//   data_in    in   ADBUS input, valid while oe = 0
//   oe         out  OE#, active-low, registered
//   rd         out  RD#, active-low, registered
//   rx_en      in   arbiter grant for the receive direction
//   rx_active  out  1 while oe = 0, registered
//   m_data     out  head byte of the buffer, registered
//   m_valid    out  buffer non-empty, registered
//   m_ready    in   consumer accepts m_data when m_valid = 1
//   overflow   out  sticky, set when a byte has to be dropped
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | oe = 1, rd = 1; bus free; wait for grant, data and room
// OE_WAIT | oe = 0, rd = 1; one-cycle bus turnaround before reading
// READ    | oe = 0, rd = 0; every edge with rxf = 0 captures a byte

module ft_sync_rx #(
    parameter int FIFO_DEPTH   = 8,
    parameter int AFULL_MARGIN = 2
) (
    input  logic       comm_clk,
    input  logic       rst,
    input  logic       rxf,
    input  logic [7:0] data_in,
    output logic       oe,
    output logic       rd,
    input  logic       rx_en,
    output logic       rx_active,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OE_WAIT = 2'd1,
        READ    = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   oe_next;
    logic   rd_next;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [7:0]    head_next;

    logic room;
    logic go;
    logic full;
    logic push_req;
    logic push;
    logic pop;

    // The margin leaves space for the byte that can still land on the
    // edge where rd is released.
    assign room     = (count < CW'(FIFO_DEPTH - AFULL_MARGIN));
    assign go       = rx_en & ~rxf & room;
    assign full     = (count == CW'(FIFO_DEPTH));
    assign push_req = (state == READ) & ~rxf;
    assign pop      = m_valid & m_ready;
    // A full buffer can still accept a byte if the head leaves on the same edge.
    assign push     = push_req & (~full | pop);

    // ---------------- FSM: state and registered strobes ----------------
    always_ff @(posedge comm_clk) begin
        if (rst) begin
            state     <= IDLE;
            oe        <= 1'b1;
            rd        <= 1'b1;
            rx_active <= 1'b0;
        end else begin
            state     <= state_next;
            oe        <= oe_next;
            rd        <= rd_next;
            rx_active <= ~oe_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (go) state_next = OE_WAIT;
            end
            OE_WAIT: begin
                state_next = go ? READ : IDLE;
            end
            READ: begin
                if (rxf || !rx_en || !room) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Strobes are derived from the next state so they change on the same
    // edge as the transition and are registered without input paths.
    always_comb begin
        oe_next = 1'b1;
        rd_next = 1'b1;
        case (state_next)
            OE_WAIT: begin
                oe_next = 1'b0;
            end
            READ: begin
                oe_next = 1'b0;
                rd_next = 1'b0;
            end
            default: begin
                oe_next = 1'b1;
                rd_next = 1'b1;
            end
        endcase
    end

    // ---------------- receive buffer ----------------
    always_comb begin
        rd_ptr_next = pop ? rd_ptr + 1'b1 : rd_ptr;
        count_next  = count + CW'(push) - CW'(pop);
        // When the buffer would otherwise be empty, the incoming byte
        // becomes the head directly instead of waiting a cycle in memory.
        if (push && ((count - CW'(pop)) == '0)) begin
            head_next = data_in;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge comm_clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge comm_clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            m_valid  <= 1'b0;
            m_data   <= 8'h00;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr  <= rd_ptr_next;
            count   <= count_next;
            m_valid <= (count_next != '0);
            if (count_next != '0) m_data <= head_next;
            if (push_req && full && !pop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ft_sync_rx.sv
// tb_ft_sync_rx: directed bench for ft_sync_rx with a behavioural FT2232H
// host (pops a byte on each edge where oe, rd and rxf are all low) and a
// consumer that records every accepted m_data byte.

module tb_ft_sync_rx;

    logic       comm_clk;
    logic       rst;
    logic       rxf;
    logic [7:0] data_in;
    logic       oe;
    logic       rd;
    logic       rx_en;
    logic       rx_active;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       overflow;

    ft_sync_rx #(.FIFO_DEPTH(8), .AFULL_MARGIN(2)) dut (
        .comm_clk  (comm_clk),
        .rst       (rst),
        .rxf       (rxf),
        .data_in   (data_in),
        .oe        (oe),
        .rd        (rd),
        .rx_en     (rx_en),
        .rx_active (rx_active),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .overflow  (overflow)
    );

    initial begin
        comm_clk = 1'b0;
        forever #5 comm_clk = ~comm_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_chk  = 0;
    int n_pass = 0;

    // host model
    logic [7:0] hbytes [64];
    int hidx      = 0;
    int hcnt      = 0;
    int pause_at  = -1;
    int pause_len = 0;
    int hold      = 0;

    // monitor state
    int         cyc    = 0;
    logic       oe_q   = 1'b1;
    logic       rd_q   = 1'b1;
    int         rd_run = 0;
    int         cap_run = 0;
    logic [7:0] rxq [$];
    int         oe_falls [$];
    int         rd_falls [$];
    int         rd_runs [$];
    int         cap_runs [$];

    int q0, f0, r0, k0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)",
                      tag, obs, obs, exp_v, exp_v);
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic int rx_at(input int i);
        if (i >= 0 && i < rxq.size()) return int'(rxq[i]);
        return -1;
    endfunction

    task automatic drive_host();
        rxf     = !(hidx < hcnt && hold == 0);
        data_in = (hidx < hcnt) ? hbytes[hidx] : 8'h00;
    endtask

    task automatic load_host(input int n, input int base, input int pa, input int pl);
        for (int i = 0; i < n; i++) hbytes[i] = 8'(base + i);
        hidx      = 0;
        hcnt      = n;
        pause_at  = pa;
        pause_len = pl;
        hold      = 0;
        drive_host();
    endtask

    // One clock: sample at negedge (pre-edge values), update host #1 after posedge.
    task automatic tick();
        logic pop_now;
        @(negedge comm_clk);
        cyc++;
        pop_now = !oe && !rd && !rxf;
        if (!rst && m_valid && m_ready) rxq.push_back(m_data);
        if (!oe && oe_q) oe_falls.push_back(cyc);
        if (!rd && rd_q) rd_falls.push_back(cyc);
        oe_q = oe;
        rd_q = rd;
        if (!rd) begin
            rd_run++;
            if (!rxf) cap_run++;
        end else if (rd_run > 0) begin
            rd_runs.push_back(rd_run);
            cap_runs.push_back(cap_run);
            rd_run  = 0;
            cap_run = 0;
        end
        @(posedge comm_clk);
        #1;
        if (pop_now) begin
            hidx++;
            if (hidx == pause_at) hold = pause_len;
        end else if (hold > 0) begin
            hold--;
        end
        drive_host();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_rx(input string tag, input int n, input int limit);
        int k = 0;
        while (rxq.size() < n && k < limit) begin
            tick();
            k++;
        end
        chk(tag, int'(rxq.size() >= n), 1);
    endtask

    task automatic wait_hidx(input string tag, input int n, input int limit);
        int k = 0;
        while (hidx < n && k < limit) begin
            tick();
            k++;
        end
        chk(tag, int'(hidx >= n), 1);
    endtask

    task automatic check_seq(input string tag, input int from, input int n, input int base);
        int errs = 0;
        for (int i = 0; i < n; i++) begin
            if (rx_at(from + i) != ((base + i) & 8'hFF)) errs++;
        end
        chk({tag, "_len"}, rxq.size() - from, n);
        chk({tag, "_order_errs"}, errs, 0);
    endtask

    task automatic snap();
        q0 = rxq.size();
        f0 = oe_falls.size();
        r0 = rd_falls.size();
        k0 = rd_runs.size();
    endtask

    initial begin
        rst     = 1'b1;
        rxf     = 1'b1;
        data_in = 8'h00;
        rx_en   = 1'b0;
        m_ready = 1'b0;
        ticks(3);

        chk("rst_oe",        oe,        1);
        chk("rst_rd",        rd,        1);
        chk("rst_rx_active", rx_active, 0);
        chk("rst_m_valid",   m_valid,   0);
        chk("rst_m_data",    m_data,    0);
        chk("rst_overflow",  overflow,  0);

        rst = 1'b0;
        ticks(2);

        // 1: single byte 0xA5
        rx_en   = 1'b1;
        m_ready = 1'b1;
        snap();
        load_host(1, 8'hA5, -1, 0);
        ticks(10);
        chk("t1_bytes",    rxq.size() - q0, 1);
        chk("t1_data",     rx_at(q0), 8'hA5);
        chk("t1_oe_to_rd", qget(rd_falls, r0) - qget(oe_falls, f0), 1);
        // one capture cycle plus the cycle in which rxf = 1 is sampled
        chk("t1_rd_low",   qget(rd_runs, k0), 2);
        chk("t1_caps",     qget(cap_runs, k0), 1);
        chk("t1_oe_end",   oe, 1);
        chk("t1_rd_end",   rd, 1);

        // 2: 20-byte burst with m_ready = 1
        snap();
        load_host(20, 8'h00, -1, 0);
        wait_rx("t2_done", q0 + 20, 80);
        ticks(3);
        check_seq("t2", q0, 20, 8'h00);
        chk("t2_bursts",   rd_runs.size() - k0, 1);
        chk("t2_caps",     qget(cap_runs, k0), 20);
        chk("t2_rd_low",   qget(rd_runs, k0), 21);
        chk("t2_overflow", overflow, 0);

        // 3: backpressure
        m_ready = 1'b0;
        snap();
        load_host(20, 8'h40, -1, 0);
        ticks(30);
        chk("t3_captured", hidx, 7);
        chk("t3_rd",       rd, 1);
        chk("t3_oe",       oe, 1);
        chk("t3_m_valid",  m_valid, 1);
        chk("t3_m_data",   m_data, 8'h40);
        chk("t3_no_pop",   rxq.size() - q0, 0);
        chk("t3_caps1",    qget(cap_runs, k0), 7);
        chk("t3_ovf_a",    overflow, 0);
        m_ready = 1'b1;
        wait_rx("t3_done", q0 + 20, 200);
        ticks(3);
        check_seq("t3", q0, 20, 8'h40);
        chk("t3_restart",  int'(rd_runs.size() - k0 >= 2), 1);
        chk("t3_ovf_b",    overflow, 0);

        // 4: rxf gap of 3 cycles after byte 5
        snap();
        load_host(12, 8'h80, 5, 3);
        wait_rx("t4_done", q0 + 12, 100);
        ticks(3);
        check_seq("t4", q0, 12, 8'h80);
        chk("t4_bursts", rd_runs.size() - k0, 2);
        chk("t4_caps1",  qget(cap_runs, k0), 5);
        chk("t4_caps2",  qget(cap_runs, k0 + 1), 7);

        // 5: rx_en drops during READ
        snap();
        load_host(20, 8'hC0, -1, 0);
        wait_hidx("t5_reach4", 4, 20);
        rx_en = 1'b0;
        tick();
        chk("t5_rd",        rd, 1);
        chk("t5_oe",        oe, 1);
        chk("t5_rx_active", rx_active, 0);
        chk("t5_captured",  hidx, 5);
        f0 = oe_falls.size();
        ticks(10);
        chk("t5_no_oe",     oe_falls.size() - f0, 0);
        chk("t5_drained",   m_valid, 0);
        chk("t5_rx_count",  rxq.size() - q0, 5);
        rx_en = 1'b1;
        wait_rx("t5_done", q0 + 20, 100);
        ticks(3);
        check_seq("t5", q0, 20, 8'hC0);

        // 6: reset mid-burst with 3 bytes buffered
        m_ready = 1'b0;
        load_host(20, 8'h60, -1, 0);
        wait_hidx("t6_reach3", 3, 20);
        rst = 1'b1;
        tick();
        chk("t6_oe",        oe, 1);
        chk("t6_rd",        rd, 1);
        chk("t6_m_valid",   m_valid, 0);
        chk("t6_overflow",  overflow, 0);
        chk("t6_rx_active", rx_active, 0);
        chk("t6_host_idx",  hidx, 4);
        rst     = 1'b0;
        m_ready = 1'b1;
        snap();
        wait_rx("t6_done", q0 + 16, 100);
        ticks(3);
        check_seq("t6", q0, 16, 8'h64);
        chk("t6_oe_to_rd", qget(rd_falls, r0) - qget(oe_falls, f0), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
